// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - start/data/stop frame serializer advanced by a tick strobe
module shift_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tick,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bits_left
);

  localparam int          FRAME_WIDTH = DATA_WIDTH + 2;
  localparam logic [15:0] LOAD_COUNT  = 16'(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic [15:0]            bits_left_q, bits_left_d;
  logic                   done_q, done_d;

  // State, frame and counters; the frame refills with ones so bit 0 is the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '1;
      bits_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bits_left_q <= bits_left_d;
      done_q      <= done_d;
    end
  end

  // Next-state: load on start in IDLE, shift on tick in SHIFT, exit once the stop bit has had its tick.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bits_left_d = bits_left_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d     = {1'b1, data_in, 1'b0};
          bits_left_d = LOAD_COUNT;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bits_left_q != 16'd0) begin
            frame_d     = {1'b1, frame_q[FRAME_WIDTH-1:1]};
            bits_left_d = bits_left_q - 16'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  assign serial_out = frame_q[0];
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign bits_left  = bits_left_q;

endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-in/serial-out frame shifter that turns a DATA_WIDTH-bit word into a start/data/stop serial frame, one bit per shift strobe. It sits directly downstream of the down-counter stage in P2. It consumes that counter's periodic strobe as its `tick` shift enable. It presents the remaining-bit count, busy and a one-cycle completion pulse to the control logic above it.

## Interface
- DATA_WIDTH, 8, number of payload bits. Frame length is DATA_WIDTH+2 (start + data + stop).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- data_in  in  DATA_WIDTH  payload; captured on the accepted start cycle only.
- tick  in  1  shift-enable strobe; one strobe advances the frame by one bit.
- serial_out  out  1  serial line, LSB-first. Idle level is 1.
- busy  out  1  high from frame load until frame end.
- done  out  1  one-cycle pulse when the stop bit has been held for a full tick interval.
- bits_left  out  16  bits still to be shifted after the current one. Zero-extended.

## Operation
- Reset value of every output while rst=1: serial_out=1, busy=0, done=0, bits_left=0. The internal frame register is cleared to all-ones and the state is IDLE.
- State machine:
  - IDLE: serial_out=1, busy=0.
  - On start=1, load frame F = {1'b1, data_in, 1'b0}, set bits_left=DATA_WIDTH+1 and go to SHIFT.
  - tick is ignored in IDLE, including when tick and start are high in the same cycle. In that case the load occurs and that tick is not counted.
- SHIFT: serial_out=F[0], busy=1.
  - On tick with bits_left>0: F <= {1'b1, F[DATA_WIDTH+1:1]} and bits_left <= bits_left-1.
  - On tick with bits_left==0: go to IDLE, pulse done=1 for one cycle, busy=0. bits_left stays 0.
  - Without tick, all state holds.
- start while in SHIFT is ignored; no queuing. data_in changes during SHIFT have no effect.
- start in the cycle done=1 is honoured, because the state is already IDLE. This gives back-to-back frames with a one-cycle line gap at level 1.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. There is no done pulse and the line returns to 1.
- Arithmetic: bits_left is an unsigned 16-bit down-count. It never wraps below 0; the zero case exits instead of decrementing.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycle 1: busy=1, serial_out=0 (start bit), bits_left=DATA_WIDTH+1.
- Each bit stays on serial_out from the cycle after one accepted tick until the cycle after the next tick.
- The k-th tick after the load moves payload bit k-1 onto the line (k=1..DATA_WIDTH). Tick DATA_WIDTH+1 moves the stop bit onto the line with bits_left=0.
- Tick DATA_WIDTH+2: on the next edge, done=1 and busy=0 for exactly one cycle. serial_out stays 1.
- Total frame cost: DATA_WIDTH+2 ticks. With tick held high continuously, that is one bit per cycle and done occurs DATA_WIDTH+3 cycles after the start sample.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst mid-operation at arbitrary phase -> same cycle serial_out=1, busy=0, done=0, bits_left=0. After release, the block stays IDLE until start.
- Basic frame, DATA_WIDTH=8: data_in=8'hA5, start one cycle, tick every 10 cycles -> line sequence 0,1,0,1,0,0,1,0,1,1. bits_left steps 9..0. done pulses once after the 10th tick and busy falls in the same cycle.
- Continuous tick=1: data_in=8'h00 -> line 0 for 9 cycles, then 1. done 11 cycles after the start sample.
- Ignored inputs: start and data_in=8'hFF pulsed during an 8'h3C frame, plus ticks while IDLE -> 8'h3C frame unchanged. There is no second frame and bits_left does not move while IDLE.
- Simultaneous start+tick in IDLE, then start in the done cycle -> the first tick is not counted (start bit lasts a full tick interval). A second frame loads with busy=1 on the cycle after done.
- Abort: rst during the 5th data bit of 8'h5A, then a new 8'h81 frame -> clean 0,1,0,0,0,0,0,0,1,1 with no residue from the aborted frame.
